// File: rtl/serial_adder_pkg.sv
// Shared types and encodings for the serial adder.
//   state_t : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   OP_ADD / OP_SUB : op input encodings
package serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-bit adder slice used by serial_adder.
//   x, y  : DIGIT-bit operand slices
//   ci    : carry in
//   sum   : DIGIT-bit sum slice
//   co    : carry out of the top bit
//   c_msb : carry into the top bit (for signed overflow)
module digit_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned DIGIT = 1
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] sum,
   output logic             co,
   output logic             c_msb
);

   logic [DIGIT:0] full;

   assign full  = {1'b0, x} + {1'b0, y} + (DIGIT+1)'(ci);
   assign sum   = full[DIGIT-1:0];
   assign co    = full[DIGIT];
   // Carry into the top bit recovered from that bit's sum and operands.
   assign c_msb = sum[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock, LSB first.
//   clk, rst        : clock, synchronous active-high reset
//   start, op, cin  : request, 0=add/1=sub, carry/borrow in (sampled with start)
//   a, b            : WIDTH-bit operands (sampled with start)
//   busy, done      : busy while slices are processed, one-cycle done pulse
//   s, cout, ovf    : registered result, carry out (sub: 1=no borrow), signed overflow
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned N     = WIDTH / DIGIT;
   localparam int unsigned CNT_W = $clog2(N + 1);

   if (DIGIT == 0 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("serial_adder: DIGIT must be nonzero, divide WIDTH and not exceed it");
   end

   state_t             state;
   logic [WIDTH-1:0]   acc_sr;   // operand A shifting out, result shifting in
   logic [WIDTH-1:0]   b_sr;
   logic               carry;
   logic [CNT_W-1:0]   cnt;
   logic [DIGIT-1:0]   dsum;
   logic               dco;
   logic               dmsb;
   logic [WIDTH-1:0]   acc_next;

   digit_adder #(.DIGIT(DIGIT)) u_digit (
      .x     (acc_sr[DIGIT-1:0]),
      .y     (b_sr[DIGIT-1:0]),
      .ci    (carry),
      .sum   (dsum),
      .co    (dco),
      .c_msb (dmsb)
   );

   // New sum slice enters at the top as the consumed A slice leaves the bottom.
   if (N == 1) begin : g_one
      assign acc_next = dsum;
   end else begin : g_multi
      assign acc_next = {dsum, acc_sr[WIDTH-1:DIGIT]};
   end

   // FSM, datapath shifters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         s      <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
         carry  <= 1'b0;
         cnt    <= '0;
         acc_sr <= '0;
         b_sr   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  acc_sr <= a;
                  b_sr   <= (op == OP_ADD) ? b : ~b;
                  carry  <= cin ^ op;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= ST_RUN;
               end
            end
            ST_RUN: begin
               acc_sr <= acc_next;
               b_sr   <= b_sr >> DIGIT;
               carry  <= dco;
               if (cnt == CNT_W'(N - 1)) begin
                  s     <= acc_next;
                  cout  <= dco;
                  ovf   <= dco ^ dmsb;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
